// File: rtl/rtdc_pkg.sv
// Shared types and constants for the RTDC time-set controller.
package rtdc_pkg;

  // Controller modes: running, editing hours, editing minutes, one-cycle load.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  // BCD upper limits: hours 23 (24-hour mode), minutes 59.
  localparam logic [1:0] HR_LIM_T  = 2'd2;
  localparam logic [3:0] HR_LIM_U  = 4'd3;
  localparam logic [2:0] MIN_LIM_T = 3'd5;
  localparam logic [3:0] MIN_LIM_U = 4'd9;

  // Width of the idle-second counter; covers timeouts up to 255 s.
  localparam int IDLE_W = 8;

endpackage

// File: rtl/bcd_field_adj.sv
// Two-digit BCD up/down register with parallel load and wrap in both
// directions. Up and down together hold the value.
module bcd_field_adj #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_t,
  input  logic [3:0]    i_load_u,
  input  logic          i_up,
  input  logic          i_down,
  input  logic [TW-1:0] i_max_t,
  input  logic [3:0]    i_max_u,
  output logic [TW-1:0] o_tens,
  output logic [3:0]    o_units
);

  logic [TW-1:0] r_t;
  logic [3:0]    r_u;
  logic [TW-1:0] w_t;
  logic [3:0]    w_u;

  // Next value: load has priority, then a single-direction step with wrap.
  always_comb begin
    w_t = r_t;
    w_u = r_u;
    if (i_load) begin
      w_t = i_load_t;
      w_u = i_load_u;
    end else if (i_up && !i_down) begin
      if (r_t == i_max_t && r_u >= i_max_u) begin
        w_t = '0;
        w_u = '0;
      end else if (r_u == 4'd9) begin
        w_t = r_t + TW'(1);
        w_u = '0;
      end else begin
        w_u = r_u + 4'd1;
      end
    end else if (i_down && !i_up) begin
      if (r_t == '0 && r_u == '0) begin
        w_t = i_max_t;
        w_u = i_max_u;
      end else if (r_u == '0) begin
        w_t = r_t - TW'(1);
        w_u = 4'd9;
      end else begin
        w_u = r_u - 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t <= '0;
      r_u <= '0;
    end else begin
      r_t <= w_t;
      r_u <= w_u;
    end
  end

  assign o_tens  = r_t;
  assign o_units = r_u;

endmodule

// File: rtl/rtdc_set_ctrl.sv
// Time-set controller: sequences RUN -> SET_HR -> SET_MIN -> COMMIT from
// debounced buttons, abandons an idle edit after TIMEOUT_S ticks, and issues
// a one-cycle load of the edited BCD time.
module rtdc_set_ctrl
  import rtdc_pkg::*;
#(
  parameter int         TIMEOUT_S = 30,
  parameter logic [1:0] HR_MAX_T  = HR_LIM_T,
  parameter logic [3:0] HR_MAX_U  = HR_LIM_U
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [1:0] cur_hr_t,
  input  logic [3:0] cur_hr_u,
  input  logic [2:0] cur_min_t,
  input  logic [3:0] cur_min_u,
  output logic       run_en,
  output logic       load,
  output logic [1:0] ld_hr_t,
  output logic [3:0] ld_hr_u,
  output logic [2:0] ld_min_t,
  output logic [3:0] ld_min_u,
  output logic       sel_hr,
  output logic       sel_min,
  output logic       blink
);

  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_S);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_mode_q, r_inc_q, r_dec_q;
  logic              r_mode_e, r_inc_e, r_dec_e;
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_next;
  logic              r_blink;
  logic              w_any_e;
  logic              w_in_set;
  logic              w_timeout;
  logic              w_up;
  logic              w_dn;

  // Registered rising-edge pulses; a held button yields one pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode_q <= 1'b0;
      r_inc_q  <= 1'b0;
      r_dec_q  <= 1'b0;
      r_mode_e <= 1'b0;
      r_inc_e  <= 1'b0;
      r_dec_e  <= 1'b0;
    end else begin
      r_mode_q <= btn_mode;
      r_inc_q  <= btn_inc;
      r_dec_q  <= btn_dec;
      r_mode_e <= btn_mode & ~r_mode_q;
      r_inc_e  <= btn_inc & ~r_inc_q;
      r_dec_e  <= btn_dec & ~r_dec_q;
    end
  end

  assign w_any_e     = r_mode_e | r_inc_e | r_dec_e;
  assign w_in_set    = (r_state == SET_HR) || (r_state == SET_MIN);
  // A button edge wins over a coincident tick: the idle count clears.
  assign w_idle_next = w_any_e  ? '0 :
                       tick_1hz ? r_idle + IDLE_W'(1) : r_idle;
  assign w_timeout   = w_in_set && (w_idle_next == TIMEOUT_V);

  // Mode edge overrides any coincident adjust edge.
  assign w_up = r_inc_e & ~r_mode_e;
  assign w_dn = r_dec_e & ~r_mode_e;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_next;
  end

  // Next-state logic: mode edge advances, idle timeout abandons the edit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (r_mode_e) w_state_next = SET_HR;
      SET_HR:  if (r_mode_e) w_state_next = SET_MIN;
               else if (w_timeout) w_state_next = RUN;
      SET_MIN: if (r_mode_e) w_state_next = COMMIT;
               else if (w_timeout) w_state_next = RUN;
      COMMIT:  w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // Idle counter lives only inside an edit; zero everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_idle <= '0;
    else if (w_in_set && !w_timeout) r_idle <= w_idle_next;
    else                            r_idle <= '0;
  end

  // Blink phase: cleared on any state change, toggles per tick while editing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_blink <= 1'b0;
    else if (!w_in_set || w_state_next != r_state) r_blink <= 1'b0;
    else if (tick_1hz)                            r_blink <= ~r_blink;
  end

  // Hour edit register: captures the running time on entry from RUN.
  bcd_field_adj #(.TW(2)) u_hr (
    .clk      (clk),
    .rst      (rst),
    .i_load   ((r_state == RUN) && r_mode_e),
    .i_load_t (cur_hr_t),
    .i_load_u (cur_hr_u),
    .i_up     ((r_state == SET_HR) && w_up),
    .i_down   ((r_state == SET_HR) && w_dn),
    .i_max_t  (HR_MAX_T),
    .i_max_u  (HR_MAX_U),
    .o_tens   (ld_hr_t),
    .o_units  (ld_hr_u)
  );

  // Minute edit register.
  bcd_field_adj #(.TW(3)) u_min (
    .clk      (clk),
    .rst      (rst),
    .i_load   ((r_state == RUN) && r_mode_e),
    .i_load_t (cur_min_t),
    .i_load_u (cur_min_u),
    .i_up     ((r_state == SET_MIN) && w_up),
    .i_down   ((r_state == SET_MIN) && w_dn),
    .i_max_t  (MIN_LIM_T),
    .i_max_u  (MIN_LIM_U),
    .o_tens   (ld_min_t),
    .o_units  (ld_min_u)
  );

  assign run_en  = (r_state == RUN);
  assign load    = (r_state == COMMIT);
  assign sel_hr  = (r_state == SET_HR);
  assign sel_min = (r_state == SET_MIN);
  assign blink   = r_blink;

endmodule

// File: tb/tb_rtdc_set_ctrl.sv
// Self-checking bench for rtdc_set_ctrl with a transaction-level time model.
module tb_rtdc_set_ctrl;

  localparam int TO = 3;
  localparam logic [2:0] M = 3'b100;
  localparam logic [2:0] I = 3'b010;
  localparam logic [2:0] D = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [1:0] cur_hr_t = '0;
  logic [3:0] cur_hr_u = '0;
  logic [2:0] cur_min_t = '0;
  logic [3:0] cur_min_u = '0;
  logic       run_en, load, sel_hr, sel_min, blink;
  logic [1:0] ld_hr_t;
  logic [3:0] ld_hr_u;
  logic [2:0] ld_min_t;
  logic [3:0] ld_min_u;

  int n_checks = 0;
  int n_fail = 0;

  // Model: m_st 0=running, 1=editing hours, 2=editing minutes.
  int m_st = 0, m_hr = 0, m_min = 0, m_idle = 0, m_blink = 0;
  int cur_h = 0, cur_m = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;
  bit prev_load = 0;

  wire [3:0]  obs    = {run_en, sel_hr, sel_min, blink};
  wire [12:0] ld_all = {ld_hr_t, ld_hr_u, ld_min_t, ld_min_u};

  always #5 clk = ~clk;

  rtdc_set_ctrl #(.TIMEOUT_S(TO), .HR_MAX_T(2'd2), .HR_MAX_U(4'd3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hr_t(cur_hr_t), .cur_hr_u(cur_hr_u), .cur_min_t(cur_min_t), .cur_min_u(cur_min_u),
    .run_en(run_en), .load(load),
    .ld_hr_t(ld_hr_t), .ld_hr_u(ld_hr_u), .ld_min_t(ld_min_t), .ld_min_u(ld_min_u),
    .sel_hr(sel_hr), .sel_min(sel_min), .blink(blink)
  );

  function automatic logic [3:0] exp_obs();
    return {m_st == 0, m_st == 1, m_st == 2, m_blink != 0};
  endfunction

  function automatic logic [12:0] pack_time(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  // Scoreboard on load strobes plus the run_en-after-load rule.
  always @(negedge clk) begin
    if (prev_load) begin
      n_checks++;
      if (run_en !== 1'b1 || load !== 1'b0) begin
        n_fail++;
        $display("FAIL post_load: run_en=%b load=%b required run_en=1 load=0", run_en, load);
      end
    end
    if (load === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_load: ld=%h required no load", ld_all);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ld_all !== mon_exp) begin
          n_fail++;
          $display("FAIL load_value: ld=%h required %h", ld_all, mon_exp);
        end
      end
    end
    prev_load = (load === 1'b1);
  end

  task automatic set_cur(input int h, input int m);
    cur_h = h;
    cur_m = m;
    cur_hr_t = 2'(h / 10);
    cur_hr_u = 4'(h % 10);
    cur_min_t = 3'(m / 10);
    cur_min_u = 4'(m % 10);
  endtask

  // Reference behaviour for one button event and/or tick in the same cycle.
  task automatic m_event(input logic [2:0] b, input bit t);
    bit moved = 0;
    if (b != 3'b000) begin
      if (b[2]) begin
        moved = 1;
        case (m_st)
          0: begin m_hr = cur_h; m_min = cur_m; m_st = 1; end
          1: m_st = 2;
          default: begin exp_q.push_back(pack_time(m_hr, m_min)); m_st = 0; end
        endcase
        m_blink = 0;
      end else if (b[1] != b[0]) begin
        if (m_st == 1) m_hr = b[1] ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
        if (m_st == 2) m_min = b[1] ? (m_min + 1) % 60 : (m_min + 59) % 60;
      end
      m_idle = 0;
    end
    if (t && !moved && m_st != 0) begin
      m_blink ^= 1;
      if (b == 3'b000) begin
        m_idle++;
        if (m_idle == TO) begin m_st = 0; m_blink = 0; m_idle = 0; end
      end
    end
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    @(negedge clk);
    {btn_mode, btn_inc, btn_dec} = b;
    repeat (hold) @(negedge clk);
    {btn_mode, btn_inc, btn_dec} = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic act(input logic [2:0] b, input int hold);
    m_event(b, 0);
    press(b, hold);
  endtask

  task automatic tick();
    m_event(3'b000, 1);
    @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if ({obs, load, ld_all} !== {4'b1000, 1'b0, 13'h0}) begin
      n_fail++;
      $display("FAIL reset_values: obs=%b load=%b ld=%h required obs=1000 load=0 ld=0000", obs, load, ld_all);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_checks++;
      if ({run_en, load, sel_hr, sel_min} !== 4'b1000) begin
        n_fail++;
        $display("FAIL idle_run: cycle %0d got %b required 1000", c, {run_en, load, sel_hr, sel_min});
      end
    end
  endtask

  task automatic test_mode_hold();
    set_cur(7, 45);
    act(M, 5);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== exp_obs()) begin
      n_fail++;
      $display("FAIL mode_hold: obs=%b required %b", obs, exp_obs());
    end
    act(M, 1);
    act(M, 1);
    n_checks++;
    if (obs !== exp_obs() || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mode_hold_commit: obs=%b pending=%0d required %b pending=0", obs, exp_q.size(), exp_obs());
    end
  endtask

  task automatic test_edit_basic();
    logic [2:0] seq[$];
    set_cur(12, 34);
    seq = '{M, I, I, I, M, D, D, M};
    foreach (seq[k]) begin
      act(seq[k], 1);
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL edit_basic step %0d: obs=%b required %b", k, obs, exp_obs());
      end
    end
  endtask

  task automatic test_wraps();
    logic [2:0] seq[$];
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin set_cur(23, 59); seq = '{M, I, M, M}; end
        1: begin set_cur(23, 59); seq = '{M, M, I, M}; end
        2: begin set_cur(0, 0);   seq = '{M, D, M, M}; end
        3: begin set_cur(0, 0);   seq = '{M, M, D, M}; end
        default: begin set_cur(9, 9); seq = '{M, I, D, D, M, I, M}; end
      endcase
      foreach (seq[k]) begin
        act(seq[k], 1);
        n_checks++;
        if (obs !== exp_obs()) begin
          n_fail++;
          $display("FAIL wrap case %0d step %0d: obs=%b required %b", c, k, obs, exp_obs());
        end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL wrap_load case %0d: pending=%0d required 0", c, exp_q.size());
      end
    end
  endtask

  task automatic test_timeout();
    set_cur(8, 15);
    act(M, 1);
    for (int k = 0; k < TO; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL timeout tick %0d: obs=%b required %b", k, obs, exp_obs());
      end
    end
    // Second pass: an inc edge coincident with the second tick restarts the count.
    act(M, 1);
    tick();
    m_event(I, 1);
    @(negedge clk);
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_obs()) begin
      n_fail++;
      $display("FAIL timeout_edge_tick: obs=%b required %b", obs, exp_obs());
    end
    for (int k = 0; k < TO; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL timeout_restart tick %0d: obs=%b required %b", k, obs, exp_obs());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] seq[$];
    set_cur(10, 20);
    seq = '{M, I | D, M | I, I | D, M | D};
    foreach (seq[k]) begin
      act(seq[k], 1);
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL simultaneous step %0d: obs=%b required %b", k, obs, exp_obs());
      end
    end
  endtask

  task automatic test_reset_mid_edit();
    set_cur(9, 41);
    act(M, 1);
    act(I, 1);
    act(M, 1);
    tick();
    n_checks++;
    if (obs !== exp_obs()) begin
      n_fail++;
      $display("FAIL pre_reset: obs=%b required %b", obs, exp_obs());
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    m_st = 0; m_idle = 0; m_blink = 0;
    n_checks++;
    if ({obs, load, ld_all} !== {4'b1000, 1'b0, 13'h0}) begin
      n_fail++;
      $display("FAIL async_reset: obs=%b load=%b ld=%h required obs=1000 load=0 ld=0000", obs, load, ld_all);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs !== exp_obs()) begin
      n_fail++;
      $display("FAIL post_reset: obs=%b required %b", obs, exp_obs());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      if (m_st == 0) set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      if ($urandom_range(0, 9) < 3) tick();
      else act(3'($urandom_range(1, 7)), $urandom_range(1, 3));
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL random op %0d: obs=%b required %b", n, obs, exp_obs());
      end
    end
    if (m_st != 0) begin
      while (m_st != 0) act(M, 1);
    end
  endtask

  initial begin
    test_reset();
    test_mode_hold();
    test_edit_basic();
    test_wraps();
    test_timeout();
    test_simultaneous();
    test_reset_mid_edit();
    test_random();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_load: pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
